mux_barrido: RTL and testbench

- Parametrised, time-multiplexed N-channel selector for the multi-digit 7-segment display path of the 0-9999 counter.
- Replaces static select-driven muxing with an internal refresh prescaler and a channel index counter.
- Inserts a blanking interval at each channel change to prevent ghosting, and adds optional leading-zero suppression.
- Feeds the BCD-to-7-segment decoder (y) and the display anodes (an).

---
 rtl/mux_barrido.sv | 94 +++++++++
 tb/tb_mux_barrido.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_barrido.sv
// Time-multiplexed N-channel display scanner with blanking between channels.
// Leading-zero suppression applies to every channel except channel 0.
module mux_barrido #(
    parameter int ancho   = 4,
    parameter int canales = 4,
    parameter int iw      = 2,
    parameter int div     = 50000,
    parameter int blank   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     lz_en,
    input  logic [canales*ancho-1:0] d,
    output logic [ancho-1:0]         y,
    output logic [canales-1:0]       an,
    output logic [iw-1:0]            idx,
    output logic                     slot
);

    localparam int cw = (div > 1) ? $clog2(div) : 1;

    logic [cw-1:0]      cnt;
    logic [cw-1:0]      cnt_n;
    logic [iw-1:0]      idx_n;
    logic [ancho-1:0]   y_n;
    logic [ancho-1:0]   sel;
    logic               sup;
    logic               sup_n;
    logic               last;
    logic               tail_zero;
    logic               lit;
    logic [canales-1:0] an_n;

    always_comb begin
        sel       = '0;
        tail_zero = 1'b1;
        for (int k = 0; k < canales; k++) begin
            if (idx == iw'(k))
                sel = d[k*ancho +: ancho];
            if (k >= int'(idx) && d[k*ancho +: ancho] != '0)
                tail_zero = 1'b0;
        end
    end

    always_comb begin
        last  = (cnt == cw'(div - 1));
        cnt_n = cnt;
        idx_n = idx;
        y_n   = y;
        sup_n = sup;
        if (en) begin
            if (cnt == '0) begin
                y_n   = sel;
                sup_n = lz_en && (idx != '0) && tail_zero;
            end
            if (last) begin
                cnt_n = '0;
                idx_n = (idx == iw'(canales - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    // Anode follows the next count so it lines up with the cnt it is shown with.
    always_comb begin
        lit  = en && (cnt_n >= cw'(blank + 1)) && !sup_n;
        an_n = '1;
        for (int k = 0; k < canales; k++) begin
            if (idx_n == iw'(k))
                an_n[k] = ~lit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            idx  <= '0;
            y    <= '0;
            sup  <= 1'b0;
            an   <= '1;
            slot <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            idx  <= idx_n;
            y    <= y_n;
            sup  <= sup_n;
            an   <= an_n;
            slot <= en && last;
        end
    end

endmodule

// File: tb/tb_mux_barrido.sv
// Scoreboard bench for mux_barrido: two configurations, random and directed
// stimulus, expectations from a cycle-level behavioural model.
module tb_mux_barrido;

    logic        clk = 1'b1;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] da = '0;
    logic [23:0] db = '0;

    logic [3:0] ya;
    logic [3:0] ana;
    logic [1:0] idxa;
    logic       slota;
    logic [3:0] yb;
    logic [5:0] anb;
    logic [2:0] idxb;
    logic       slotb;

    always #5 clk = ~clk;

    mux_barrido #(.ancho(4), .canales(4), .iw(2), .div(10), .blank(2)) dut_a (
        .clk(clk), .reset(reset), .en(en), .lz_en(lz_en), .d(da),
        .y(ya), .an(ana), .idx(idxa), .slot(slota)
    );

    mux_barrido #(.ancho(4), .canales(6), .iw(3), .div(4), .blank(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .lz_en(lz_en), .d(db),
        .y(yb), .an(anb), .idx(idxb), .slot(slotb)
    );

    typedef struct {
        logic [3:0]  y;
        logic [15:0] an;
        logic [3:0]  idx;
        logic        slot;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    int nch[2] = '{4, 6};
    int dv[2]  = '{10, 4};
    int bl[2]  = '{2, 0};
    int mcnt[2];
    int midx[2];
    int my[2];
    bit msup[2];

    function automatic int digit(logic [63:0] dd, int k);
        return int'((dd >> (4 * k)) & 64'hF);
    endfunction

    // Expected outputs after the coming rising edge for unit u.
    function automatic exp_t step(int u, bit r, bit e, bit lz, logic [63:0] dd);
        exp_t x;
        bit z;
        x.an = 16'((1 << nch[u]) - 1);
        x.slot = 1'b0;
        if (r) begin
            mcnt[u] = 0;
            midx[u] = 0;
            my[u] = 0;
            msup[u] = 0;
        end else if (e) begin
            if (mcnt[u] == 0) begin
                my[u] = digit(dd, midx[u]);
                z = 1;
                for (int k = midx[u]; k < nch[u]; k++)
                    if (digit(dd, k) != 0) z = 0;
                msup[u] = lz && midx[u] != 0 && z;
            end
            x.slot = (mcnt[u] == dv[u] - 1);
            mcnt[u] = (mcnt[u] + 1) % dv[u];
            if (mcnt[u] == 0) midx[u] = (midx[u] + 1) % nch[u];
            if (mcnt[u] > bl[u] && !msup[u]) x.an[midx[u]] = 1'b0;
        end
        x.y = 4'(my[u]);
        x.idx = 4'(midx[u]);
        return x;
    endfunction

    task automatic drive(bit r, bit e, bit lz, logic [15:0] a, logic [23:0] b);
        @(negedge clk);
        reset = r;
        en = e;
        lz_en = lz;
        da = a;
        db = b;
        qa.push_back(step(0, r, e, lz, {48'b0, a}));
        qb.push_back(step(1, r, e, lz, {40'b0, b}));
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() == 0 || qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow at %0t: got empty queue expected entry", $time);
            end else begin
                x = qa.pop_front();
                chk("a_y", int'(ya), int'(x.y));
                chk("a_an", int'(ana), int'(x.an[3:0]));
                chk("a_idx", int'(idxa), int'(x.idx));
                chk("a_slot", int'(slota), int'(x.slot));
                x = qb.pop_front();
                chk("b_y", int'(yb), int'(x.y));
                chk("b_an", int'(anb), int'(x.an[5:0]));
                chk("b_idx", int'(idxb), int'(x.idx));
                chk("b_slot", int'(slotb), int'(x.slot));
            end
        end
    end

    function automatic logic [23:0] rnd_digits();
        logic [23:0] v = '0;
        for (int k = 0; k < 6; k++)
            if ($urandom_range(0, 1) == 1)
                v[k*4 +: 4] = 4'($urandom_range(1, 15));
        return v;
    endfunction

    initial begin
        logic [15:0] pats[3];
        logic [23:0] rb;
        bit r;
        bit e;
        bit lz;
        pats = '{16'h0051, 16'h0000, 16'h0501};

        repeat (3) drive(1, 1, 0, 16'h4321, 24'h654321);
        while (mcnt[0] != 6) drive(0, 1, 0, 16'h4321, 24'h654321);
        drive(1, 1, 0, 16'h4321, 24'h654321);
        repeat (45) drive(0, 1, 0, 16'h4321, 24'h654321);

        foreach (pats[i])
            repeat (45) drive(0, 1, 1, pats[i], 24'h054000);

        while (!(mcnt[0] == 5 && midx[0] == 1))
            drive(0, 1, 0, 16'h4321, 24'h654321);
        repeat (4) drive(0, 0, 0, 16'h4321, 24'h654321);
        repeat (30) drive(0, 1, 0, 16'h4321, 24'h654321);

        while (!(mcnt[0] == 4 && midx[0] == 2))
            drive(0, 1, 0, 16'h4321, 24'h654321);
        repeat (50) drive(0, 1, 0, 16'h4921, 24'h654321);

        rb = rnd_digits();
        lz = 0;
        repeat (700) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                rb = rnd_digits();
                lz = 1'($urandom_range(0, 1));
            end
            drive(r, e, lz, rb[15:0], rb);
        end

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
